// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: FSM state encoding, protocol constants and the
// default word width agreed with the downstream address/data FSM.
package spi_pkg;
   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} spi_state_t;

   localparam int SPI_MODE0     = 1;
   localparam int MSB_FIRST     = 1;
   localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/spi_shift_register.sv
// Generic MSB-first shift register with parallel load; load wins over shift.
module spi_shift_register #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             load_en,
   input  logic             serial_in,
   input  logic [width-1:0] parallel_in,
   output logic [width-1:0] parallel_out,
   output logic             serial_out
);
   logic [width-1:0] r_shift;

   always_ff @(posedge clk) begin
      if (reset)
         r_shift <= '0;
      else if (load_en)
         r_shift <= parallel_in;
      else if (shift_en)
         r_shift <= {r_shift[width-2:0], serial_in};
   end

   assign parallel_out = r_shift;
   assign serial_out   = r_shift[width-1];
endmodule

// File: rtl/spi_frame_shifter.sv
// SPI mode-0 frame engine: assembles MOSI bits into words and serialises the
// transmit word onto MISO, reloading it at each word boundary for gapless words.
module spi_frame_shifter
   import spi_pkg::*;
#(
   parameter int width      = DEFAULT_WIDTH,
   parameter int countwidth = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs_n,
   input  logic             sclk_posedge,
   input  logic             sclk_negedge,
   input  logic             mosi,
   input  logic [width-1:0] tx_data,
   output logic [width-1:0] rx_data,
   output logic             rx_valid,
   output logic             miso,
   output logic             miso_en,
   output logic             busy
);
   localparam logic [countwidth-1:0] LAST_BIT = countwidth'(width - 1);

   spi_state_t             r_state;
   logic [countwidth-1:0]  r_bit_cnt;
   logic                   r_reload;
   logic [width-1:0]       r_rx_data;
   logic                   r_rx_valid;
   logic                   r_miso_en;
   logic                   r_busy;

   logic                   w_run;
   logic                   w_rx_shift;
   logic                   w_tx_edge;
   logic                   w_tx_load;
   logic                   w_tx_shift;
   logic [width-1:0]       w_rx_word;
   logic                   w_tx_msb;
   logic                   w_rx_ser_unused;
   logic [width-1:0]       w_tx_par_unused;

   // cs_n high beats any edge pulse; a posedge masks a coincident negedge.
   assign w_run      = (r_state == ACTIVE) && !cs_n;
   assign w_rx_shift = w_run && sclk_posedge;
   assign w_tx_edge  = w_run && sclk_negedge && !sclk_posedge;
   assign w_tx_load  = ((r_state == IDLE) && !cs_n) || (w_tx_edge && r_reload);
   assign w_tx_shift = w_tx_edge && !r_reload;

   spi_shift_register #(.width(width)) u_rx_shift (
      .clk          (clk),
      .reset        (reset),
      .shift_en     (w_rx_shift),
      .load_en      (1'b0),
      .serial_in    (mosi),
      .parallel_in  ('0),
      .parallel_out (w_rx_word),
      .serial_out   (w_rx_ser_unused)
   );

   spi_shift_register #(.width(width)) u_tx_shift (
      .clk          (clk),
      .reset        (reset),
      .shift_en     (w_tx_shift),
      .load_en      (w_tx_load),
      .serial_in    (1'b0),
      .parallel_in  (tx_data),
      .parallel_out (w_tx_par_unused),
      .serial_out   (w_tx_msb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_bit_cnt  <= '0;
         r_reload   <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_miso_en  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!cs_n) begin
                  r_state   <= ACTIVE;
                  r_busy    <= 1'b1;
                  r_miso_en <= 1'b1;
                  r_bit_cnt <= '0;
                  r_reload  <= 1'b0;
               end
            end
            ACTIVE: begin
               if (cs_n) begin
                  r_state   <= IDLE;
                  r_busy    <= 1'b0;
                  r_miso_en <= 1'b0;
                  r_bit_cnt <= '0;
                  r_reload  <= 1'b0;
               end else if (sclk_posedge) begin
                  if (r_bit_cnt == LAST_BIT) begin
                     r_rx_data  <= {w_rx_word[width-2:0], mosi};
                     r_rx_valid <= 1'b1;
                     r_bit_cnt  <= '0;
                     r_reload   <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else if (sclk_negedge && r_reload) begin
                  r_reload <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign miso     = w_tx_msb && r_busy;
   assign miso_en  = r_miso_en;
   assign busy     = r_busy;

   a_no_dual_edge: assert property (@(posedge clk) disable iff (reset)
      !(sclk_posedge && sclk_negedge));
endmodule

// File: tb/tb_spi_frame_shifter.sv
// Directed bench for spi_frame_shifter: inputs driven and outputs sampled on
// the falling clk edge, so every rising edge sees stable stimulus.
module tb_spi_frame_shifter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cs_n = 1'b1;
   logic       sclk_posedge = 1'b0;
   logic       sclk_negedge = 1'b0;
   logic       mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] tx_next = 8'h00;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       miso;
   logic       miso_en;
   logic       busy;

   int pass_cnt = 0;
   int total    = 0;
   int vcnt     = 0;

   always #5 clk = ~clk;

   spi_frame_shifter #(.width(8), .countwidth(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .cs_n         (cs_n),
      .sclk_posedge (sclk_posedge),
      .sclk_negedge (sclk_negedge),
      .mosi         (mosi),
      .tx_data      (tx_data),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .miso         (miso),
      .miso_en      (miso_en),
      .busy         (busy)
   );

   task automatic step();
      @(negedge clk);
      if (rx_valid === 1'b1) vcnt++;
   endtask

   // One SCLK period; m = MISO as the master samples it at the rising edge,
   // v = rx_valid one clk after the posedge pulse.
   task automatic sbit(input logic b, output logic m, output logic v);
      m = miso;
      mosi = b;
      sclk_posedge = 1'b1;
      step();
      sclk_posedge = 1'b0;
      v = rx_valid;
      if (rx_valid === 1'b1) tx_data = tx_next;
      step();
      sclk_negedge = 1'b1;
      step();
      sclk_negedge = 1'b0;
      step();
   endtask

   task automatic word(input logic [7:0] bits, output logic [7:0] misos, output logic [7:0] vflags);
      for (int i = 7; i >= 0; i--) sbit(bits[i], misos[i], vflags[i]);
   endtask

   task automatic test_reset();
      logic m, v;
      int   v0;
      reset = 1'b1;
      step(); step();
      total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data); else pass_cnt++;
      total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else pass_cnt++;
      total++; if ({miso, miso_en, busy} !== 3'b000) $display("FAIL reset_ctrl got %b exp 000", {miso, miso_en, busy}); else pass_cnt++;
      // reset in the middle of a frame with edge pulses present
      reset = 1'b0; tx_data = 8'hFF; tx_next = 8'hFF; cs_n = 1'b0;
      step();
      for (int i = 0; i < 7; i++) sbit(1'b1, m, v);
      v0 = vcnt;
      reset = 1'b1; mosi = 1'b1; sclk_posedge = 1'b1;
      step();
      sclk_posedge = 1'b0; sclk_negedge = 1'b1;
      step();
      sclk_negedge = 1'b0; reset = 1'b0; cs_n = 1'b1;
      total++; if ({miso, miso_en, busy} !== 3'b000) $display("FAIL midreset_ctrl got %b exp 000", {miso, miso_en, busy}); else pass_cnt++;
      total++; if (rx_data !== 8'h00) $display("FAIL midreset_rx_data got %h exp 00", rx_data); else pass_cnt++;
      step();
      total++; if (vcnt !== v0) $display("FAIL midreset_no_valid got %0d exp %0d", vcnt - v0, 0); else pass_cnt++;
   endtask

   task automatic test_single_word();
      logic [7:0] ms, vf;
      int v0;
      tx_data = 8'hA5; tx_next = 8'hA5; cs_n = 1'b0;
      step();
      total++; if ({busy, miso_en, miso} !== 3'b111) $display("FAIL start_ctrl got %b exp 111", {busy, miso_en, miso}); else pass_cnt++;
      v0 = vcnt;
      word(8'b1100_1010, ms, vf);
      total++; if (rx_data !== 8'hCA) $display("FAIL single_rx_data got %h exp ca", rx_data); else pass_cnt++;
      total++; if (ms !== 8'hA5) $display("FAIL single_miso_seq got %b exp 10100101", ms); else pass_cnt++;
      total++; if (vf !== 8'h01) $display("FAIL single_valid_timing got %b exp 00000001", vf); else pass_cnt++;
      total++; if (vcnt - v0 !== 1) $display("FAIL single_valid_count got %0d exp 1", vcnt - v0); else pass_cnt++;
      cs_n = 1'b1;
      step();
      total++; if ({busy, miso_en, miso} !== 3'b000) $display("FAIL end_ctrl got %b exp 000", {busy, miso_en, miso}); else pass_cnt++;
   endtask

   task automatic test_abort();
      logic m, v;
      logic [7:0] ms, vf;
      int v0;
      tx_data = 8'h00; tx_next = 8'h00; cs_n = 1'b0;
      step();
      v0 = vcnt;
      sbit(1'b1, m, v); sbit(1'b0, m, v); sbit(1'b1, m, v); sbit(1'b1, m, v); sbit(1'b0, m, v);
      cs_n = 1'b1;
      step();
      total++; if (vcnt !== v0) $display("FAIL abort_no_valid got %0d exp 0", vcnt - v0); else pass_cnt++;
      total++; if (rx_data !== 8'hCA) $display("FAIL abort_rx_hold got %h exp ca", rx_data); else pass_cnt++;
      total++; if ({busy, miso_en} !== 2'b00) $display("FAIL abort_ctrl got %b exp 00", {busy, miso_en}); else pass_cnt++;
      cs_n = 1'b0;
      step();
      word(8'h81, ms, vf);
      total++; if (rx_data !== 8'h81) $display("FAIL abort_next_rx got %h exp 81", rx_data); else pass_cnt++;
      total++; if (vf !== 8'h01) $display("FAIL abort_next_timing got %b exp 00000001", vf); else pass_cnt++;
      cs_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] ms1, ms2, vf;
      int v0;
      tx_data = 8'h5A; tx_next = 8'h3C; cs_n = 1'b0;
      step();
      v0 = vcnt;
      word(8'h12, ms1, vf);
      total++; if (rx_data !== 8'h12) $display("FAIL b2b_rx1 got %h exp 12", rx_data); else pass_cnt++;
      total++; if (ms1 !== 8'h5A) $display("FAIL b2b_miso1 got %b exp 01011010", ms1); else pass_cnt++;
      word(8'hF0, ms2, vf);
      total++; if (rx_data !== 8'hF0) $display("FAIL b2b_rx2 got %h exp f0", rx_data); else pass_cnt++;
      total++; if (ms2 !== 8'h3C) $display("FAIL b2b_miso2 got %b exp 00111100", ms2); else pass_cnt++;
      total++; if (vcnt - v0 !== 2) $display("FAIL b2b_valid_count got %0d exp 2", vcnt - v0); else pass_cnt++;
      cs_n = 1'b1;
      step();
   endtask

   task automatic test_idle_ignore();
      int v0, bad_en, bad_busy;
      v0 = vcnt; bad_en = 0; bad_busy = 0;
      cs_n = 1'b1;
      for (int i = 0; i < 24; i++) begin
         mosi = i[0];
         sclk_posedge = (i % 3 == 0);
         sclk_negedge = (i % 3 == 1);
         step();
         if (miso_en !== 1'b0) bad_en++;
         if (busy !== 1'b0) bad_busy++;
      end
      sclk_posedge = 1'b0; sclk_negedge = 1'b0;
      step();
      total++; if (vcnt !== v0) $display("FAIL idle_no_valid got %0d exp 0", vcnt - v0); else pass_cnt++;
      total++; if (bad_en !== 0) $display("FAIL idle_miso_en got %0d bad cycles exp 0", bad_en); else pass_cnt++;
      total++; if (bad_busy !== 0) $display("FAIL idle_busy got %0d bad cycles exp 0", bad_busy); else pass_cnt++;
      total++; if (rx_data !== 8'hF0) $display("FAIL idle_rx_hold got %h exp f0", rx_data); else pass_cnt++;
   endtask

   task automatic test_cs_edge_collision();
      logic m, v;
      int v0;
      tx_data = 8'hFF; tx_next = 8'hFF; cs_n = 1'b0;
      step();
      v0 = vcnt;
      for (int i = 0; i < 7; i++) sbit(1'b1, m, v);
      cs_n = 1'b1; mosi = 1'b1; sclk_posedge = 1'b1;
      step();
      sclk_posedge = 1'b0;
      total++; if (busy !== 1'b0) $display("FAIL collide_idle got busy %b exp 0", busy); else pass_cnt++;
      step(); step();
      total++; if (vcnt !== v0) $display("FAIL collide_no_valid got %0d exp 0", vcnt - v0); else pass_cnt++;
      total++; if (rx_data !== 8'hF0) $display("FAIL collide_rx_hold got %h exp f0", rx_data); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_abort();
      test_back_to_back();
      test_idle_ignore();
      test_cs_edge_collision();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
